// File: rtl/seg_disp_arbiter.sv
// Arbitrates the 6-digit BCD display between a base source and two requesters,
// applies per-digit blink masking and generates the digit-scan enable.
module seg_disp_arbiter #(
  parameter int         SCAN_DIV    = 50000,
  parameter int         BLINK_TICKS = 250,
  parameter int         MIN_HOLD    = 1000,
  parameter logic [3:0] BLANK_CODE  = 4'hf
) (
  input  logic        clk,
  input  logic        rst_,
  input  logic [23:0] src0_bcd,
  input  logic [5:0]  src0_blink,
  input  logic        src1_req,
  input  logic [23:0] src1_bcd,
  input  logic [5:0]  src1_blink,
  input  logic        src2_req,
  input  logic [23:0] src2_bcd,
  input  logic [5:0]  src2_blink,
  output logic [1:0]  gnt,
  output logic [1:0]  owner,
  output logic [23:0] bcd_out,
  output logic        scan_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD);

  typedef enum logic [1:0] {
    ST_BASE = 2'd0,
    ST_OWN1 = 2'd1,
    ST_OWN2 = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [HW-1:0] hold_q, hold_d, hold_dec;
  logic        tick_q, tick_d;
  logic        phase_q, phase_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  owner_q, owner_d;
  logic [23:0] bcd_q, bcd_d;
  logic [23:0] sel_bcd;
  logic [5:0]  sel_blink;

  always_comb begin
    pre_d   = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
    tick_d  = (pre_q == PRE_MAX);
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (tick_q) begin
      if (bcnt_q == BLINK_MAX) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end else begin
      bcnt_d = bcnt_q;
    end
  end

  // Hold only counts down once the owner's request has gone; any entry reloads it.
  always_comb begin
    state_d  = state_q;
    hold_dec = (tick_q && (hold_q != '0)) ? hold_q - HW'(1) : hold_q;
    hold_d   = hold_q;
    case (state_q)
      ST_BASE: begin
        if (src2_req) begin
          state_d = ST_OWN2;
          hold_d  = HOLD_LOAD;
        end else if (src1_req) begin
          state_d = ST_OWN1;
          hold_d  = HOLD_LOAD;
        end else begin
          hold_d = '0;
        end
      end
      ST_OWN1: begin
        if (src2_req) begin
          state_d = ST_OWN2;
          hold_d  = HOLD_LOAD;
        end else if (src1_req) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          state_d = ST_BASE;
        end else begin
          hold_d = hold_dec;
        end
      end
      ST_OWN2: begin
        if (src2_req) begin
          hold_d = HOLD_LOAD;
        end else if (hold_q == '0) begin
          if (src1_req) begin
            state_d = ST_OWN1;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = ST_BASE;
          end
        end else begin
          hold_d = hold_dec;
        end
      end
      default: begin
        state_d = ST_BASE;
        hold_d  = '0;
      end
    endcase
  end

  // Outputs follow the next state so a request change shows up one edge later.
  always_comb begin
    case (state_d)
      ST_OWN1: begin
        owner_d   = 2'd1;
        gnt_d     = 2'b01;
        sel_bcd   = src1_bcd;
        sel_blink = src1_blink;
      end
      ST_OWN2: begin
        owner_d   = 2'd2;
        gnt_d     = 2'b10;
        sel_bcd   = src2_bcd;
        sel_blink = src2_blink;
      end
      default: begin
        owner_d   = 2'd0;
        gnt_d     = 2'b00;
        sel_bcd   = src0_bcd;
        sel_blink = src0_blink;
      end
    endcase
    bcd_d = sel_bcd;
    for (int k = 0; k < 6; k++) begin
      if (sel_blink[k] && !phase_q) begin
        bcd_d[4*k +: 4] = BLANK_CODE;
      end else begin
        bcd_d[4*k +: 4] = sel_bcd[4*k +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_BASE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      bcnt_q  <= '0;
      phase_q <= 1'b1;
      hold_q  <= '0;
      gnt_q   <= 2'b00;
      owner_q <= 2'd0;
      bcd_q   <= {6{BLANK_CODE}};
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      bcd_q   <= bcd_d;
    end
  end

  assign gnt       = gnt_q;
  assign owner     = owner_q;
  assign bcd_out   = bcd_q;
  assign scan_tick = tick_q;

endmodule
